div_unit: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M divide/remainder ops: DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage. The ALU covers single-cycle add/sub/logic/compare; this block is the multi-cycle inverse of multiply.
- Operands are accepted with a valid/ready handshake. The result is returned with a second valid/ready handshake, so the pipeline can stall on it.

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 182 ++++++++++++++++++
 tb/tb_div_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - operand/result handshake interface for div_unit
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            div_zero;

  modport master (
    output in_valid, op, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  in_valid, op, dividend, divisor, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (option: DIV_UNIT_EARLY_OUT_EN)
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  div_unit_if.slave  io
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            rem_sel_q, rem_sel_d;     // 1: REM/REMU returns remainder
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            special_q, special_d;
  logic            div_zero_q, div_zero_d;
  logic [XLEN-1:0] special_res_q, special_res_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            is_div0;
  logic            is_ovf;
  logic            special_in;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] rem_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;
  logic [XLEN-1:0] res_full;

  // Handshake: a flush cycle never accepts, so ready is withheld during it
  assign io.in_ready = (state_q == IDLE) && !flush;
  assign accept      = io.in_valid && io.in_ready;

  // Operand decode: signs, magnitudes and RISC-V special cases
  always_comb begin
    is_signed   = ~io.op[0];
    a_neg       = is_signed & io.dividend[XLEN-1];
    b_neg       = is_signed & io.divisor[XLEN-1];
    a_mag       = a_neg ? -io.dividend : io.dividend;
    b_mag       = b_neg ? -io.divisor  : io.divisor;
    is_div0     = (io.divisor == '0);
    is_ovf      = is_signed && (io.dividend == MIN_NEG) && (io.divisor == '1);
    special_in  = is_div0 || is_ovf;
    if (is_div0) begin
      special_val = io.op[1] ? io.dividend : '1;
    end else begin
      special_val = io.op[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  always_comb begin
    rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    diff      = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    rem_sel_d     = rem_sel_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    special_d     = special_q;
    div_zero_d    = div_zero_q;
    special_res_d = special_res_q;
    dvsr_d        = dvsr_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = CALC;
          rem_sel_d     = io.op[1];
          neg_quo_d     = a_neg ^ b_neg;
          neg_rem_d     = a_neg;
          special_d     = special_in;
          div_zero_d    = is_div0;
          special_res_d = special_val;
          dvsr_d        = b_mag;
          rem_d         = '0;
          quo_d         = a_mag;
          cnt_d         = '0;
`ifdef DIV_UNIT_EARLY_OUT_EN
          // Special cases need no iterations: a single CALC cycle, then DONE
          if (special_in) begin
            cnt_d = CNT_LAST;
          end
`endif
        end
      end
      CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else; the pending result is simply dropped
    if (flush) begin
      state_d = IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_sel_q     <= 1'b0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      div_zero_q    <= 1'b0;
      special_res_q <= '0;
      dvsr_q        <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
    end else begin
      rem_sel_q     <= rem_sel_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      special_q     <= special_d;
      div_zero_q    <= div_zero_d;
      special_res_q <= special_res_d;
      dvsr_q        <= dvsr_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
    end
  end

  // Sign fix-up from registered state; special results bypass it
  always_comb begin
    fix_quo  = neg_quo_q ? -quo_q : quo_q;
    fix_rem  = neg_rem_q ? -rem_q : rem_q;
    res_full = special_q ? special_res_q : (rem_sel_q ? fix_rem : fix_quo);
  end

  assign io.out_valid = (state_q == DONE);
  assign io.result    = (state_q == DONE) ? res_full : '0;
  assign io.div_zero  = (state_q == DONE) && div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
module tb_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];   // {div_zero, result}

  // Reference model using the language's own signed/unsigned division
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        sgn;
    sgn = ~op[0];
    if (b == 32'h0) return {1'b1, (op[1] ? a : 32'hFFFF_FFFF)};
    if (sgn && a == MIN_NEG && b == 32'hFFFF_FFFF) return {1'b0, (op[1] ? 32'h0 : MIN_NEG)};
    if (sgn) begin
      if (op[1]) r = $signed(a) % $signed(b);
      else       r = $signed(a) / $signed(b);
    end else begin
      if (op[1]) r = a % b;
      else       r = a / b;
    end
    return {1'b0, r};
  endfunction

  function automatic int lat_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    special = (b == 32'h0) || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
`ifdef DIV_UNIT_EARLY_OUT_EN
    return special ? 1 : XLEN;
`else
    return special ? XLEN : XLEN;
`endif
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Drive one op, wait for its result, hold it for 'hold' cycles, then hand it off
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] res, output logic dz, output int lat, output bit rdy_seen,
                       output bit unstable, output bit rdy_next);
    bit done;
    exp_q.push_back(model(op, a, b));
    issue(op, a, b);
    lat = 0; rdy_seen = 0; unstable = 0; rdy_next = 0; done = 0;
    res = '0; dz = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) done = 1;
      else if (bus.in_ready) rdy_seen = 1;
    end
    if (!done) begin
      lat = -1;
      return;
    end
    res = bus.result;
    dz  = bus.div_zero;
    if (bus.in_ready) rdy_seen = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== res || bus.div_zero !== dz || bus.in_ready) unstable = 1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    rdy_next = bus.in_ready && !bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 2'b00; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 0", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b expected 0", bus.div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Run a table of ops and compare each against the scoreboard
  task automatic run_table(input string name, input vec_t tbl [$], input int hold);
    logic [31:0] res; logic dz; int lat; bit rs, us, rn;
    logic [32:0] exp;
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, hold, res, dz, lat, rs, us, rn);
      exp = exp_q.pop_front();
      checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL %s[%0d] result got %h expected %h", name, i, res, exp[31:0]); end
      checks++; if (dz !== exp[32]) begin errors++; $display("FAIL %s[%0d] div_zero got %b expected %b", name, i, dz, exp[32]); end
      checks++; if (lat != lat_exp(tbl[i].op, tbl[i].a, tbl[i].b)) begin errors++; $display("FAIL %s[%0d] latency got %0d expected %0d", name, i, lat, lat_exp(tbl[i].op, tbl[i].a, tbl[i].b)); end
      checks++; if (rs !== 1'b0) begin errors++; $display("FAIL %s[%0d] in_ready_busy got %b expected 0", name, i, rs); end
      checks++; if (rn !== 1'b1) begin errors++; $display("FAIL %s[%0d] in_ready_after got %b expected 1", name, i, rn); end
    end
  endtask

  task automatic test_basic();
    vec_t t [$];
    t = '{'{2'b00, 32'd7, 32'd2}, '{2'b10, 32'd7, 32'd2}};
    run_table("basic", t, 0);
  endtask

  task automatic test_signed_unsigned();
    vec_t t [$];
    t = '{'{2'b00, 32'hFFFF_FFF9, 32'd2}, '{2'b10, 32'hFFFF_FFF9, 32'd2},
          '{2'b01, 32'hFFFF_FFFF, 32'h10}, '{2'b11, 32'hFFFF_FFFF, 32'h10},
          '{2'b00, 32'd7, 32'hFFFF_FFFE},   '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE}};
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.op = 2'($urandom_range(0, 3));
      v.a  = $urandom;
      v.b  = $urandom >> $urandom_range(0, 31);
      if (v.b == 32'h0) v.b = 32'd3;
      t.push_back(v);
    end
    run_table("arith", t, 0);
  endtask

  task automatic test_special();
    vec_t t [$];
    t = '{'{2'b00, 32'd5, 32'd0},         '{2'b10, 32'd5, 32'd0},
          '{2'b01, 32'd5, 32'd0},         '{2'b11, 32'hDEAD_BEEF, 32'd0},
          '{2'b00, MIN_NEG, 32'hFFFF_FFFF}, '{2'b10, MIN_NEG, 32'hFFFF_FFFF},
          '{2'b01, MIN_NEG, 32'hFFFF_FFFF}, '{2'b00, 32'd0, 32'd0}};
    run_table("special", t, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] res; logic dz; int lat; bit rs, us, rn;
    logic [32:0] exp;
    vec_t t [$];
    do_op(2'b00, 32'd1000, 32'hFFFF_FFF9, 10, res, dz, lat, rs, us, rn);
    exp = exp_q.pop_front();
    checks++; if (res !== exp[31:0]) begin errors++; $display("FAIL bp_result got %h expected %h", res, exp[31:0]); end
    checks++; if (us !== 1'b0) begin errors++; $display("FAIL bp_stable got unstable=%b expected 0", us); end
    checks++; if (rn !== 1'b1) begin errors++; $display("FAIL bp_in_ready_next got %b expected 1", rn); end
    t = '{'{2'b11, 32'd12345, 32'd100}};
    run_table("after_bp", t, 0);
  endtask

  task automatic test_flush();
    bit seen;
    vec_t t [$];
    issue(2'b01, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b expected 1", bus.in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b expected 0", seen); end
    // flush in IDLE with a valid request: nothing may be accepted
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 2'b00; bus.dividend = 32'd8; bus.divisor = 32'd2;
    flush = 1'b1;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_flush_in_ready got %b expected 1", bus.in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_flush_accept got %b expected 0", seen); end
    t = '{'{2'b11, 32'd100, 32'd7}};
    run_table("post_flush", t, 0);
  endtask

  task automatic test_reset_mid();
    vec_t t [$];
    issue(2'b00, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h expected 0", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL rst_mid_div_zero got %b expected 0", bus.div_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    t = '{'{2'b00, 32'hFFFF_FF9C, 32'h0000_000A}};
    run_table("post_reset", t, 0);
  endtask

  task automatic test_back_to_back();
    vec_t t [$];
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.op = 2'(i);
      v.a  = $urandom;
      v.b  = 32'($urandom_range(1, 1000));
      t.push_back(v);
    end
    run_table("b2b", t, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_unsigned();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
